// File: rtl/sw_addr_dec_pkg.sv
// Shared types and helpers for the switch-instance dispatch scheduler.
// Holds the pending-state encoding and the round-robin pick function.
package sw_addr_dec_pkg;

    localparam int OP_ID_W = 8;
    localparam int RR_MAX  = 32;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_PEND = 1'b1
    } pend_st_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Scans from the highest offset down so the lowest offset from ptr wins.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0] free,
        input logic [4:0]        ptr,
        input logic [5:0]        n
    );
        rr_pick_t   r;
        logic [5:0] c;
        r = '0;
        for (int k = RR_MAX - 1; k >= 0; k--) begin
            c = {1'b0, ptr} + 6'(k);
            if (c >= n) c = c - n;
            if (6'(k) < n && free[c[4:0]]) begin
                r.found = 1'b1;
                r.idx   = c[4:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_dispatch_sched_if.sv
// Request, busy and dispatch signals between the request source,
// the scheduler and the switch array.
interface sw_dispatch_sched_if
    import sw_addr_dec_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int A_WIDTH     = 8
);
    logic                          req_valid;
    logic                          req_ready;
    logic [OP_ID_W-1:0]            req_op_id;
    logic [A_WIDTH-1:0]            req_addr;
    logic [NUM_SW_INST-1:0]        sw_busy;
    logic [NUM_SW_INST-1:0]        sel_en;
    logic [OP_ID_W-1:0]            op_id;
    logic [A_WIDTH-1:0]            addr_out;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          pend_err;

    modport master (
        output req_valid, req_op_id, req_addr, sw_busy,
        input  req_ready, sel_en, op_id, addr_out,
        input  fifo_level, pend_err
    );

    modport slave (
        input  req_valid, req_op_id, req_addr, sw_busy,
        output req_ready, sel_en, op_id, addr_out,
        output fifo_level, pend_err
    );

endinterface

// File: rtl/sw_req_fifo.sv
// Request queue for the dispatch scheduler; full/empty come from the
// occupancy count, pointers wrap naturally at the power-of-2 depth.
module sw_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic          push;
    logic          pop;

    assign push = push_i && !full_o;
    assign pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/sw_dispatch_sched.sv
// Queues read requests and dispatches each to a free switch instance
// with a one-hot sel_en pulse, round-robin, with a pending-confirm timeout.
module sw_dispatch_sched
    import sw_addr_dec_pkg::*;
#(
    parameter int NUM_SW_INST = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int A_WIDTH     = 8,
    parameter int PEND_TMO    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sw_dispatch_sched_if.slave  sif
);
    localparam int IW = $clog2(NUM_SW_INST);
    localparam int PW = OP_ID_W + A_WIDTH;
    localparam logic [3:0] TMO_LAST = 4'(PEND_TMO - 1);
    localparam logic [NUM_SW_INST-1:0] ONE = NUM_SW_INST'(1);

    logic [PW-1:0]               head;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        empty;
    logic                        full;
    logic                        push;
    logic                        pop;

    pend_st_e                    ps_q  [NUM_SW_INST];
    logic [3:0]                  tmr_q [NUM_SW_INST];
    logic [IW-1:0]               rr_q;
    logic [NUM_SW_INST-1:0]      sel_q;
    logic [OP_ID_W-1:0]          op_q;
    logic [A_WIDTH-1:0]          addr_q;
    logic                        err_q;
    logic [NUM_SW_INST-1:0]      pend_mask;
    logic [NUM_SW_INST-1:0]      free;
    rr_pick_t                    pick;

    assign push = sif.req_valid && !full;

    sw_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({sif.req_op_id, sif.req_addr}),
        .rdata_o (head),
        .level_o (level),
        .empty_o (empty),
        .full_o  (full)
    );

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < NUM_SW_INST; i++)
            pend_mask[i] = (ps_q[i] == PS_PEND);
    end

    assign free = ~sif.sw_busy & ~pend_mask;
    assign pick = rr_pick(RR_MAX'(free), 5'(rr_q), 6'(NUM_SW_INST));
    assign pop  = !empty && pick.found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            op_q   <= '0;
            addr_q <= '0;
            rr_q   <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_SW_INST; i++) begin
                ps_q[i]  <= PS_IDLE;
                tmr_q[i] <= '0;
            end
        end else begin
            sel_q <= '0;
            for (int i = 0; i < NUM_SW_INST; i++) begin
                if (ps_q[i] == PS_PEND) begin
                    if (sif.sw_busy[i]) begin
                        ps_q[i] <= PS_IDLE;
                    end else if (tmr_q[i] == TMO_LAST) begin
                        ps_q[i] <= PS_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        tmr_q[i] <= tmr_q[i] + 1'b1;
                    end
                end
                // A winner is never pending, so this cannot fight the above.
                if (pop && pick.idx == 5'(i)) begin
                    ps_q[i]  <= PS_PEND;
                    tmr_q[i] <= '0;
                end
            end
            if (pop) begin
                sel_q           <= ONE << pick.idx;
                {op_q, addr_q}  <= head;
                rr_q <= (pick.idx == 5'(NUM_SW_INST - 1)) ?
                        '0 : IW'(pick.idx + 5'd1);
            end
        end
    end

    assign sif.req_ready  = !full;
    assign sif.sel_en     = sel_q;
    assign sif.op_id      = op_q;
    assign sif.addr_out   = addr_q;
    assign sif.fifo_level = level;
    assign sif.pend_err   = err_q;

endmodule
